// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum accumulator: default widths, FSM encoding
// and the output clamp used when PSUM_SAT_EN is defined.
package psum_pkg;

  localparam int ACC_W_DEF = 48;
  localparam int OUT_W_DEF = 32;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  // Clamp happens when the bits above the result's sign bit disagree with the sign.
  function automatic logic [OUT_W_DEF-1:0] sat_clamp(input logic [ACC_W_DEF-1:0] v);
    logic [ACC_W_DEF-OUT_W_DEF:0] top;
    top = v[ACC_W_DEF-1:OUT_W_DEF-1];
    if ((&top) || (~|top))
      return v[OUT_W_DEF-1:0];
    return v[ACC_W_DEF-1] ? {1'b1, {(OUT_W_DEF-1){1'b0}}} : {1'b0, {(OUT_W_DEF-1){1'b1}}};
  endfunction

endpackage

// File: rtl/psum_fifo2.sv
// Two-entry synchronous FIFO holding {beats, data} results for the accumulator output.
module psum_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_valid,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop     = pop && (count != 2'd0);
  assign do_push    = push && ((count != 2'd2) || do_pop);
  assign head_data  = mem[rd_ptr];
  assign head_valid = (count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      if (do_push && !do_pop)
        count <= count + 2'd1;
      else if (!do_push && do_pop)
        count <= count - 2'd1;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates adder-tree sums over a K-tile and queues one result per tile.
// Define PSUM_SAT_EN to clamp results to OUT_W instead of wrapping.
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int TREE_LAT  = 3,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int MAX_BEATS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [31:0]      sum_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [15:0]      out_beats,
  output logic             err_len
);

  localparam int BW = $clog2(MAX_BEATS) + 1;
  localparam int IW = $clog2(TREE_LAT + 2);
  localparam int FW = BW + OUT_W;

  logic                accepted;
  logic                last_acc;
  logic [TREE_LAT-1:0] v_sr;
  logic [TREE_LAT-1:0] l_sr;
  logic                v_d;
  logic                l_d;
  logic [IW-1:0]       infl;
  logic [1:0]          fifo_cnt;
  logic [IW:0]         occ;
  state_t              state_q;
  state_t              state_d;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_d;
  logic [BW-1:0]       beats_q;
  logic [BW-1:0]       beats_d;
  logic                push;
  logic                err_set;
  logic [ACC_W-1:0]    sum_ext;
  logic [OUT_W-1:0]    res_data;
  logic [FW-1:0]       head;

  assign accepted = in_valid && in_ready;
  assign last_acc = accepted && in_last;
  assign v_d      = v_sr[TREE_LAT-1];
  assign l_d      = l_sr[TREE_LAT-1];
  assign sum_ext  = {{(ACC_W-32){sum_in[31]}}, sum_in};

  // Reserving a FIFO slot per in-flight tile lets the non-stallable tree always retire.
  assign occ      = (IW+1)'(fifo_cnt) + (IW+1)'(infl);
  assign in_ready = (occ < (IW+1)'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      v_sr <= '0;
      l_sr <= '0;
      infl <= '0;
    end else begin
      v_sr <= (v_sr << 1) | TREE_LAT'(accepted);
      l_sr <= (l_sr << 1) | TREE_LAT'(last_acc);
      if (last_acc && !l_d)
        infl <= infl + IW'(1);
      else if (!last_acc && l_d)
        infl <= infl - IW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    beats_d = beats_q;
    push    = 1'b0;
    err_set = 1'b0;
    if (v_d) begin
      push    = l_d;
      state_d = l_d ? S_IDLE : S_ACC;
      if (state_q == S_ACC) begin
        acc_d = acc_q + sum_ext;
        if (beats_q == BW'(MAX_BEATS))
          err_set = 1'b1;
        else
          beats_d = beats_q + BW'(1);
      end else begin
        acc_d   = sum_ext;
        beats_d = BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      beats_q <= '0;
      err_len <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      beats_q <= beats_d;
      if (err_set)
        err_len <= 1'b1;
    end
  end

`ifdef PSUM_SAT_EN
  assign res_data = sat_clamp(acc_d);
`else
  assign res_data = acc_d[OUT_W-1:0];
`endif

  psum_fifo2 #(
    .W(FW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({beats_d, res_data}),
    .pop       (out_ready),
    .head_data (head),
    .head_valid(out_valid),
    .count     (fifo_cnt)
  );

  assign out_data  = head[OUT_W-1:0];
  assign out_beats = 16'(head[FW-1:OUT_W]);

endmodule
